hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-stage register info in, stall/flush/forward controls out.
// The controller takes the slave modport; the pipeline/bench drives through master.
interface hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_id, rs2_id;
  logic             use_rs1_id, use_rs2_id;
  logic [4:0]       rd_ex;
  logic             mem2reg_ex;
  logic [4:0]       rd_mem, rd_wb;
  logic             regwr_mem, regwr_wb;
  logic             branch_mem;
  logic [XLEN-1:0]  target_mem;
  logic             mem_busy;
  logic [1:0]       forward_rs1, forward_rs2;
  logic             stall_pc, bubble_ex, flush, freeze;
  logic [XLEN-1:0]  pc_out;
  logic [CNT_W-1:0] cnt_stall, cnt_flush;

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem2reg_ex,
           rd_mem, rd_wb, regwr_mem, regwr_wb, branch_mem, target_mem, mem_busy,
    output forward_rs1, forward_rs2, stall_pc, bubble_ex, flush, freeze,
           pc_out, cnt_stall, cnt_flush
  );

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem2reg_ex,
           rd_mem, rd_wb, regwr_mem, regwr_wb, branch_mem, target_mem, mem_busy,
    input  forward_rs1, forward_rs2, stall_pc, bubble_ex, flush, freeze,
           pc_out, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: operand forwarding, load-use stalls,
// taken-branch flushes, memory freeze, fetch PC and saturating perf counters.
module hazard_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              FLUSH_DEPTH = 2,
  parameter int              LOAD_LAT    = 1,
  parameter int              CNT_W       = 16
) (
  input logic          clk,
  input logic          clr,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [2:0] FL_REM = 3'(FLUSH_DEPTH - 1);
  localparam logic [2:0] LD_REM = 3'(LOAD_LAT - 1);

  state_t           state;
  logic [2:0]       rem;
  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] cnt_stall, cnt_flush;

  logic load_use, accept_br, stall, active;

  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                     input logic ww, input logic [4:0] rdw);
    if (wm && rdm == rs && rs != 5'd0)      return 2'b10;
    else if (ww && rdw == rs && rs != 5'd0) return 2'b01;
    else                                    return 2'b00;
  endfunction

  assign load_use = bus.mem2reg_ex && bus.rd_ex != 5'd0 &&
                    ((bus.use_rs1_id && bus.rd_ex == bus.rs1_id) ||
                     (bus.use_rs2_id && bus.rd_ex == bus.rs2_id));

  // active: a cycle in which the pipeline actually moves
  assign active    = !clr && !bus.mem_busy;
  assign accept_br = active && bus.branch_mem && state != FLUSH;
  assign stall     = active && !accept_br &&
                     (state == STALL || (state == RUN && load_use));

  assign bus.forward_rs1 = clr ? 2'b00 : fwd(bus.rs1_id, bus.regwr_mem, bus.rd_mem, bus.regwr_wb, bus.rd_wb);
  assign bus.forward_rs2 = clr ? 2'b00 : fwd(bus.rs2_id, bus.regwr_mem, bus.rd_mem, bus.regwr_wb, bus.rd_wb);
  assign bus.freeze      = !clr && bus.mem_busy;
  assign bus.flush       = clr || accept_br || (active && state == FLUSH);
  assign bus.stall_pc    = stall;
  assign bus.bubble_ex   = stall;
  assign bus.pc_out      = pc;
  assign bus.cnt_stall   = cnt_stall;
  assign bus.cnt_flush   = cnt_flush;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= RUN;
      rem       <= 3'd0;
      pc        <= RESET_PC;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else if (!bus.mem_busy) begin
      if (accept_br) begin
        pc <= {bus.target_mem[XLEN-1:2], 2'b00};
        if (cnt_flush != '1) cnt_flush <= cnt_flush + 1'b1;
        if (FLUSH_DEPTH > 1) begin
          state <= FLUSH;
          rem   <= FL_REM;
        end else begin
          state <= RUN;
          rem   <= 3'd0;
        end
      end else if (stall) begin
        if (cnt_stall != '1) cnt_stall <= cnt_stall + 1'b1;
        if (state == RUN) begin
          if (LOAD_LAT > 1) begin
            state <= STALL;
            rem   <= LD_REM;
          end
        end else if (rem <= 3'd1) begin
          state <= RUN;
          rem   <= 3'd0;
        end else begin
          rem <= rem - 3'd1;
        end
      end else begin
        pc <= pc + XLEN'(4);
        case (state)
          FLUSH: begin
            if (rem <= 3'd1) begin
              state <= RUN;
              rem   <= 3'd0;
            end else begin
              rem <= rem - 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LOAD_LAT=2, FLUSH_DEPTH=2, CNT_W=4.
module tb_hazard_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic clr;
  int   total  = 0;
  int   passes = 0;

  hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .XLEN(XLEN), .RESET_PC(32'h0), .FLUSH_DEPTH(2), .LOAD_LAT(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.rs1_id = 0; bus.rs2_id = 0; bus.use_rs1_id = 0; bus.use_rs2_id = 0;
    bus.rd_ex = 0; bus.mem2reg_ex = 0; bus.rd_mem = 0; bus.rd_wb = 0;
    bus.regwr_mem = 0; bus.regwr_wb = 0; bus.branch_mem = 0;
    bus.target_mem = '0; bus.mem_busy = 0;
  endtask

  task automatic load_use_on();
    bus.mem2reg_ex = 1; bus.rd_ex = 5'd7; bus.rs2_id = 5'd7; bus.use_rs2_id = 1;
  endtask

  task automatic branch(input logic [31:0] tgt);
    bus.branch_mem = 1; bus.target_mem = tgt;
  endtask

  initial begin
    idle();
    clr = 1;
    // forwarding would match here, but reset forces 00
    bus.rs1_id = 5'd5; bus.rd_mem = 5'd5; bus.regwr_mem = 1;
    #1;
    chk("clr_flush", bus.flush, 1);
    chk("clr_stall", bus.stall_pc, 0);
    chk("clr_freeze", bus.freeze, 0);
    chk("clr_fwd1", bus.forward_rs1, 2'b00);
    tick(); tick();
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_cnt_stall", bus.cnt_stall, 0);
    chk("rst_cnt_flush", bus.cnt_flush, 0);

    clr = 0; idle();
    #1;
    chk("run_flush", bus.flush, 0);
    tick();
    chk("first_pc", bus.pc_out, 32'h4);
    tick(); tick(); tick();
    chk("pc_0x10", bus.pc_out, 32'h10);

    // forwarding priority
    bus.rs1_id = 5'd5; bus.rd_mem = 5'd5; bus.rd_wb = 5'd5;
    bus.regwr_mem = 1; bus.regwr_wb = 1; #1;
    chk("fwd_mem", bus.forward_rs1, 2'b10);
    bus.regwr_mem = 0; #1;
    chk("fwd_wb", bus.forward_rs1, 2'b01);
    bus.rs1_id = 5'd0; bus.rd_mem = 5'd0; bus.rd_wb = 5'd0; #1;
    chk("fwd_x0", bus.forward_rs1, 2'b00);
    bus.rs2_id = 5'd3; bus.rd_mem = 5'd3; bus.regwr_mem = 1; #1;
    chk("fwd2_mem", bus.forward_rs2, 2'b10);
    chk("fwd1_none", bus.forward_rs1, 2'b00);
    idle();
    bus.mem2reg_ex = 1; bus.rd_ex = 5'd0; bus.use_rs1_id = 1; #1;
    chk("lu_rd0", bus.bubble_ex, 0);
    idle();

    // load-use, LOAD_LAT=2
    load_use_on(); #1;
    chk("lu_bubble0", bus.bubble_ex, 1);
    chk("lu_stallpc0", bus.stall_pc, 1);
    tick();
    chk("lu_pc0", bus.pc_out, 32'h10);
    idle(); #1;
    chk("lu_bubble1", bus.bubble_ex, 1);
    tick();
    chk("lu_pc1", bus.pc_out, 32'h10);
    chk("lu_cnt", bus.cnt_stall, 2);
    chk("lu_done", bus.bubble_ex, 0);
    tick();
    chk("lu_adv", bus.pc_out, 32'h14);

    // taken branch with a second branch and load-use ignored in FLUSH
    branch(32'h103); #1;
    chk("br_flush0", bus.flush, 1);
    tick();
    chk("br_pc", bus.pc_out, 32'h100);
    chk("br_cnt", bus.cnt_flush, 1);
    branch(32'h200); load_use_on(); #1;
    chk("br_flush1", bus.flush, 1);
    chk("br_nostall", bus.bubble_ex, 0);
    tick();
    chk("br_ign_pc", bus.pc_out, 32'h104);
    chk("br_ign_cnt", bus.cnt_flush, 1);
    chk("br_ign_cs", bus.cnt_stall, 2);
    idle(); #1;
    chk("br_flush_end", bus.flush, 0);
    tick();
    chk("br_adv", bus.pc_out, 32'h108);

    // freeze in the middle of a flush
    branch(32'h40);
    tick();
    chk("fz_pc", bus.pc_out, 32'h40);
    bus.mem_busy = 1; #1;
    chk("fz_freeze", bus.freeze, 1);
    chk("fz_flush", bus.flush, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fz_hold", bus.pc_out, 32'h40);
    end
    chk("fz_cnt", bus.cnt_flush, 2);
    idle(); #1;
    chk("fz_flush_rest", bus.flush, 1);
    chk("fz_unfreeze", bus.freeze, 0);
    tick();
    chk("fz_pc_adv", bus.pc_out, 32'h44);
    chk("fz_flush_done", bus.flush, 0);
    tick();

    // branch aborts a stall
    load_use_on();
    tick();
    chk("sb_pc", bus.pc_out, 32'h48);
    idle(); branch(32'h80); #1;
    chk("sb_flush", bus.flush, 1);
    chk("sb_nobubble", bus.bubble_ex, 0);
    tick();
    chk("sb_pc_tgt", bus.pc_out, 32'h80);
    chk("sb_cs", bus.cnt_stall, 3);
    chk("sb_cf", bus.cnt_flush, 3);
    idle();
    tick();
    chk("sb_pc_adv", bus.pc_out, 32'h84);

    // reset in the middle of STALL
    load_use_on();
    tick();
    idle(); clr = 1; #1;
    chk("rs_flush", bus.flush, 1);
    chk("rs_bubble", bus.bubble_ex, 0);
    tick();
    chk("rs_pc", bus.pc_out, 32'h0);
    chk("rs_cs", bus.cnt_stall, 0);
    chk("rs_cf", bus.cnt_flush, 0);
    clr = 0; #1;
    chk("rs_run", bus.bubble_ex, 0);
    tick();
    chk("rs_pc4", bus.pc_out, 32'h4);

    // PC wrap
    branch(32'hFFFF_FFFF);
    tick();
    chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    idle();
    tick();
    chk("wrap_zero", bus.pc_out, 32'h0);

    // flush counter saturation (CNT_W=4)
    for (int i = 0; i < 16; i++) begin
      branch(32'h200);
      tick();
      idle();
      tick();
    end
    chk("sat_cf", bus.cnt_flush, 4'hF);

    // reset overrides mem_busy
    bus.mem_busy = 1; clr = 1;
    tick();
    chk("rb_pc", bus.pc_out, 32'h0);
    chk("rb_cf", bus.cnt_flush, 0);
    clr = 0; idle();
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
